// File: rtl/jk_shift_pkg.sv
// jk_shift_pkg: command and FSM state encodings shared by the jk_shift_register slice.
package jk_shift_pkg;
    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        LOAD   = 3'd1,
        SHL    = 3'd2,
        SHR    = 3'd3,
        JK     = 3'd4,
        ROTL_N = 3'd5,
        ROTR_N = 3'd6,
        CLEAR  = 3'd7
    } op_e;
    typedef enum logic {
        IDLE = 1'b0,
        ROT  = 1'b1
    } state_e;
endpackage

// File: rtl/jk_shift_register_if.sv
// jk_shift_register_if: command/status bundle; q_shadow exists only with JK_SHIFT_SHADOW_EN.
interface jk_shift_register_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH);
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             sin;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] invq;
    logic             sout;
    logic             busy;
    logic             done;
`ifdef JK_SHIFT_SHADOW_EN
    logic [WIDTH-1:0] q_shadow;
`endif
    modport master (
        output op_valid, op, d, j, k, sin, amt,
        input  q, invq, sout, busy, done
`ifdef JK_SHIFT_SHADOW_EN
        , input q_shadow
`endif
    );
    modport slave (
        input  op_valid, op, d, j, k, sin, amt,
        output q, invq, sout, busy, done
`ifdef JK_SHIFT_SHADOW_EN
        , output q_shadow
`endif
    );
endinterface

// File: rtl/jk_bit_cell.sv
// jk_bit_cell: one JK flip-flop whose next state can be overridden by a load value.
module jk_bit_cell (
    input  logic clk,
    input  logic r,
    input  logic en_i,
    input  logic ld_i,
    input  logic ld_val_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);
    logic q_q, q_d;
    always_comb begin
        q_d = !en_i ? q_q : ld_i ? ld_val_i : (j_i & k_i) ? ~q_q : j_i ? 1'b1 : k_i ? 1'b0 : q_q;
    end
    always_ff @(posedge clk or negedge r) begin
        if (!r) q_q <= 1'b0;
        else    q_q <= q_d;
    end
    assign q_o = q_q;
endmodule

// File: rtl/jk_shift_register.sv
// jk_shift_register: WIDTH-bit load/shift/JK/clear register with multi-cycle rotate-by-N.
// Define JK_SHIFT_SHADOW_EN to add q_shadow, which only follows q on done cycles.
module jk_shift_register
    import jk_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic r,
    jk_shift_register_if.slave bus
);
    localparam int AMT_W = $clog2(WIDTH);
    state_e           state_q;
    logic [AMT_W-1:0] cnt_q;
    logic             dir_q, busy_q, done_q, sout_q;
    logic [WIDTH-1:0] q, ld_val, rl, rr;
    logic             accept, rot, ld, en;
    op_e              op_c;
    assign rl = {q[WIDTH-2:0], q[WIDTH-1]};
    assign rr = {q[0], q[WIDTH-1:1]};
    always_comb begin
        op_c   = op_e'(bus.op);
        accept = bus.op_valid & ~busy_q;
        rot    = state_q == ROT;
        ld     = rot | (accept & (op_c inside {LOAD, SHL, SHR, CLEAR}));
        en     = ld | (accept & (op_c == JK));
        ld_val = rot ? (dir_q ? rr : rl) :
                 op_c == LOAD ? bus.d :
                 op_c == SHL  ? {q[WIDTH-2:0], bus.sin} :
                 op_c == SHR  ? {bus.sin, q[WIDTH-1:1]} : '0;
    end
    // Every bit shares the same enable/override; only the data and J/K differ per bit.
    for (genvar b = 0; b < WIDTH; b++) begin : g_cell
        jk_bit_cell u_cell (
            .clk      (clk),
            .r        (r),
            .en_i     (en),
            .ld_i     (ld),
            .ld_val_i (ld_val[b]),
            .j_i      (bus.j[b]),
            .k_i      (bus.k[b]),
            .q_o      (q[b])
        );
    end
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ROT) begin
                sout_q <= dir_q ? q[0] : q[WIDTH-1];
                cnt_q  <= cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else if (accept) begin
                if (op_c == SHL) sout_q <= q[WIDTH-1];
                if (op_c == SHR) sout_q <= q[0];
                if ((op_c == ROTL_N || op_c == ROTR_N) && bus.amt != '0) begin
                    cnt_q   <= bus.amt;
                    dir_q   <= op_c == ROTR_N;
                    state_q <= ROT;
                    busy_q  <= 1'b1;
                end else begin
                    done_q <= 1'b1;
                end
            end
        end
    end
`ifdef JK_SHIFT_SHADOW_EN
    logic [WIDTH-1:0] shadow_q;
    always_ff @(posedge clk or negedge r) begin
        if (!r)          shadow_q <= '0;
        else if (done_q) shadow_q <= q;
    end
    assign bus.q_shadow = shadow_q;
`endif
    assign bus.q    = q;
    assign bus.invq = ~q;
    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_jk_shift_register.sv
// tb_jk_shift_register: directed scenarios plus randomized ops against a behavioural model.
module tb_jk_shift_register;
    logic clk = 1'b0;
    logic r   = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] m_q;
    logic       m_sout;
    jk_shift_register_if #(.WIDTH(8)) bus ();
    jk_shift_register #(.WIDTH(8)) dut (.clk(clk), .r(r), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        int s = n % 8;
        return (x << s) | (x >> (8 - s));
    endfunction
    function automatic logic [7:0] rotr(input logic [7:0] x, input int n);
        int s = n % 8;
        return (x >> s) | (x << (8 - s));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] dd, input logic [7:0] jj,
                         input logic [7:0] kk, input logic s, input logic [2:0] a);
        bus.op_valid = 1'b1;
        bus.op = o; bus.d = dd; bus.j = jj; bus.k = kk; bus.sin = s; bus.amt = a;
        step();
        bus.op_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        bus.op_valid = 1'b0; bus.op = 3'd0; bus.d = '0; bus.j = '0; bus.k = '0;
        bus.sin = 1'b0; bus.amt = '0;
        r = 1'b0;
        step(); step();
        chk("reset_q", bus.q, 8'h00);
        chk("reset_invq", bus.invq, 8'hFF);
        chk("reset_busy", {7'b0, bus.busy}, 8'h00);
        chk("reset_done", {7'b0, bus.done}, 8'h00);
        chk("reset_sout", {7'b0, bus.sout}, 8'h00);
        r = 1'b1;
        step();
    endtask

    task automatic test_load();
        issue(3'd1, 8'hA5, 8'h00, 8'h00, 1'b0, 3'd0);
        chk("load_q", bus.q, 8'hA5);
        chk("load_invq", bus.invq, 8'h5A);
        chk("load_done", {7'b0, bus.done}, 8'h01);
        step();
        chk("load_done_once", {7'b0, bus.done}, 8'h00);
        chk("load_q_hold", bus.q, 8'hA5);
    endtask

    task automatic test_shift();
        issue(3'd2, 8'h00, 8'h00, 8'h00, 1'b1, 3'd0);
        chk("shl_q", bus.q, 8'h4B);
        chk("shl_sout", {7'b0, bus.sout}, 8'h01);
        issue(3'd3, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
        chk("shr_q", bus.q, 8'h25);
        chk("shr_sout", {7'b0, bus.sout}, 8'h01);
        chk("shr_done", {7'b0, bus.done}, 8'h01);
    endtask

    task automatic test_jk();
        issue(3'd1, 8'hF0, 8'h00, 8'h00, 1'b0, 3'd0);
        issue(3'd4, 8'h00, 8'h0F, 8'hCC, 1'b0, 3'd0);
        chk("jk_q", bus.q, 8'h3F);
        chk("jk_sout_kept", {7'b0, bus.sout}, 8'h01);
    endtask

    task automatic test_rotate();
        issue(3'd1, 8'h81, 8'h00, 8'h00, 1'b0, 3'd0);
        issue(3'd5, 8'h00, 8'h00, 8'h00, 1'b0, 3'd3);
        chk("rot_busy_start", {7'b0, bus.busy}, 8'h01);
        chk("rot_q_start", bus.q, 8'h81);
        chk("rot_done_start", {7'b0, bus.done}, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            bus.op_valid = 1'b1; bus.op = 3'd1; bus.d = 8'hFF;
            step();
            chk($sformatf("rot_q_%0d", i), bus.q, rotl(8'h81, i));
            chk($sformatf("rot_busy_%0d", i), {7'b0, bus.busy}, {7'b0, i < 3});
            chk($sformatf("rot_done_%0d", i), {7'b0, bus.done}, {7'b0, i == 3});
        end
        bus.op_valid = 1'b0;
        chk("rot_sout", {7'b0, bus.sout}, {7'b0, rotl(8'h81, 3) & 8'h01});
        step();
        chk("rot_done_once", {7'b0, bus.done}, 8'h00);
        chk("rot_load_ignored", bus.q, 8'h0C);
    endtask

    task automatic test_rotr0();
        issue(3'd1, 8'h3C, 8'h00, 8'h00, 1'b0, 3'd0);
        issue(3'd6, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
        chk("rotr0_q", bus.q, 8'h3C);
        chk("rotr0_busy", {7'b0, bus.busy}, 8'h00);
        chk("rotr0_done", {7'b0, bus.done}, 8'h01);
    endtask

    task automatic test_abort();
        issue(3'd1, 8'h55, 8'h00, 8'h00, 1'b0, 3'd0);
        issue(3'd5, 8'h00, 8'h00, 8'h00, 1'b0, 3'd5);
        step();
        chk("abort_mid_q", bus.q, 8'hAA);
        #2 r = 1'b0;
        #1;
        chk("abort_q", bus.q, 8'h00);
        chk("abort_busy", {7'b0, bus.busy}, 8'h00);
        step();
        r = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_done", {6'b0, bus.done, bus.busy}, 8'h00);
        end
        issue(3'd1, 8'h9C, 8'h00, 8'h00, 1'b0, 3'd0);
        chk("abort_reload_q", bus.q, 8'h9C);
        chk("abort_reload_done", {7'b0, bus.done}, 8'h01);
        m_q = 8'h9C;
        m_sout = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic [2:0] o = 3'($urandom_range(0, 7));
            logic [2:0] a = 3'($urandom_range(0, 7));
            logic [7:0] dd = 8'($urandom);
            logic [7:0] jj = 8'($urandom);
            logic [7:0] kk = 8'($urandom);
            logic       s  = 1'($urandom);
            int         cyc = 0;
            case (o)
                3'd1: m_q = dd;
                3'd2: begin m_sout = m_q[7]; m_q = {m_q[6:0], s}; end
                3'd3: begin m_sout = m_q[0]; m_q = {s, m_q[7:1]}; end
                3'd4: m_q = (jj & ~m_q) | (~kk & m_q);
                3'd5: if (a != 0) begin m_q = rotl(m_q, a); m_sout = m_q[0]; end
                3'd6: if (a != 0) begin m_q = rotr(m_q, a); m_sout = m_q[7]; end
                3'd7: m_q = 8'h00;
                default: ;
            endcase
            issue(o, dd, jj, kk, s, a);
            if ((o == 3'd5 || o == 3'd6) && a != 0) begin
                for (int c = 1; c <= int'(a); c++) begin
                    bus.op_valid = 1'($urandom);
                    bus.op = 3'($urandom); bus.d = 8'($urandom); bus.amt = 3'($urandom);
                    step();
                    cyc++;
                    if (c < int'(a)) chk("rand_busy_mid", {6'b0, bus.busy, bus.done}, 8'h02);
                end
                bus.op_valid = 1'b0;
            end
            chk($sformatf("rand_done_op%0d_cyc%0d", o, cyc), {6'b0, bus.busy, bus.done}, 8'h01);
            chk($sformatf("rand_q_op%0d", o), bus.q, m_q);
            chk("rand_invq", bus.invq, ~m_q);
            chk("rand_sout", {7'b0, bus.sout}, {7'b0, m_sout});
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift();
        test_jk();
        test_rotate();
        test_rotr0();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
